multicycle_control: RTL and testbench

Multicycle sequencer for the LEGv8 datapath subset (AND/ORR/ADD/SUB reg, ADDI/SUBI, LDUR/STUR, B, CBZ). It sits between the instruction register and the shared datapath (register file, ALU, single unified memory). It drives one datapath phase per cycle: fetch, decode, execute, memory and write-back. It handles the memory ready handshake, a wait-timeout, and trapping on illegal opcodes.

---
 rtl/multicycle_control.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 sequencer: fetch/decode/exec/mem/wb phases, memory wait timeout, illegal-op trap.
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module multicycle_control #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        pcsrc,
  output logic        memread,
  output logic        memwrite,
  output logic        regwrite,
  output logic        reg2loc,
  output logic        alusrc,
  output logic        mem2reg,
  output logic [3:0]  aluop,
  output logic [1:0]  signop,
  output logic [2:0]  state,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0] instret,
`endif
  output logic        halted
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsAnd, ClsOrr, ClsAdd, ClsSub, ClsAddi, ClsSubi, ClsLdur, ClsStur, ClsB, ClsCbz
  } class_e;

  localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

  state_e     state_q, state_d;
  class_e     class_q, class_d, class_dec;
  logic [7:0] wait_q, wait_d;

  // Priority order matters: overlapping patterns resolve to the first listed class.
  function automatic class_e decode_op(input logic [10:0] op);
    casez (op)
      11'b?1?10001???: return ClsSubi;
      11'b?00101?????: return ClsB;
      11'b?011010????: return ClsCbz;
      11'b??111000010: return ClsLdur;
      11'b?0001010???: return ClsAnd;
      11'b?0101010???: return ClsOrr;
      11'b?0?01011???: return ClsAdd;
      11'b?1?01011???: return ClsSub;
      11'b?0?10001???: return ClsAddi;
      11'b??111000000: return ClsStur;
      default:         return ClsNone;
    endcase
  endfunction

  always_comb class_dec = decode_op(opcode);

  always_comb begin
    state_d  = state_q;
    class_d  = class_q;
    wait_d   = wait_q;
    mem_req  = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    pcsrc    = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    reg2loc  = 1'b0;
    alusrc   = 1'b0;
    mem2reg  = 1'b0;
    aluop    = 4'b0000;
    signop   = 2'b00;
    halted   = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = StDecode;
        end else if (wait_q == WaitMax) begin
          state_d = StTrap;
        end
      end
      StDecode: begin
        class_d = class_dec;
        state_d = (class_dec == ClsNone) ? StTrap : StExec;
      end
      StExec: begin
        state_d = StWb;
        case (class_q)
          ClsAnd:  aluop = 4'b0000;
          ClsOrr:  aluop = 4'b0001;
          ClsAdd:  aluop = 4'b0010;
          ClsSub:  aluop = 4'b0110;
          ClsAddi: begin aluop = 4'b0010; alusrc = 1'b1; reg2loc = 1'b1; end
          ClsSubi: begin aluop = 4'b0110; alusrc = 1'b1; reg2loc = 1'b1; end
          ClsLdur: begin
            aluop = 4'b0010; alusrc = 1'b1; signop = 2'b01; state_d = StMem;
          end
          ClsStur: begin
            aluop = 4'b0010; alusrc = 1'b1; reg2loc = 1'b1; signop = 2'b01; state_d = StMem;
          end
          ClsB: begin
            signop = 2'b10; pcwrite = 1'b1; pcsrc = 1'b1; state_d = StFetch;
          end
          ClsCbz: begin
            aluop = 4'b0111; reg2loc = 1'b1; signop = 2'b11;
            pcsrc = 1'b1; pcwrite = zero; state_d = StFetch;
          end
          default: state_d = StTrap;
        endcase
      end
      StMem: begin
        mem_req  = 1'b1;
        alusrc   = 1'b1;
        aluop    = 4'b0010;
        signop   = 2'b01;
        memread  = (class_q == ClsLdur);
        memwrite = (class_q == ClsStur);
        if (mem_ready) begin
          if (class_q == ClsLdur)      state_d = StWb;
          else if (class_q == ClsStur) state_d = StFetch;
          else                         state_d = StTrap;
        end else if (wait_q == WaitMax) begin
          state_d = StTrap;
        end
      end
      StWb: begin
        regwrite = 1'b1;
        mem2reg  = (class_q == ClsLdur);
        state_d  = StFetch;
      end
      StTrap:  halted  = 1'b1;
      default: state_d = StTrap;
    endcase

    if ((state_d == StFetch || state_d == StMem) && state_d != state_q) begin
      wait_d = 8'd0;
    end else if (mem_req && mem_ready) begin
      wait_d = 8'd0;
    end else if (mem_req) begin
      wait_d = wait_q + 8'd1;
    end

    // Reset silences every strobe immediately, including the FETCH request.
    if (Reset) begin
      mem_req  = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      pcsrc    = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      reg2loc  = 1'b0;
      alusrc   = 1'b0;
      mem2reg  = 1'b0;
      aluop    = 4'b0000;
      signop   = 2'b00;
      halted   = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StFetch;
      class_q <= ClsNone;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
    end
  end

  assign state = state_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instret_q, instret_d;
  logic        retire;

  always_comb begin
    retire = (state_q == StWb) ||
             (state_q == StExec && (class_q == ClsB || class_q == ClsCbz)) ||
             (state_q == StMem && class_q == ClsStur && mem_ready);
    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) instret_q <= 32'd0;
    else       instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: phase sequencing, strobes, waits, trap, timeout, reset abort.
module tb_multicycle_control;

  logic        CLK, Reset;
  logic [10:0] opcode;
  logic        zero, mem_ready;
  logic        mem_req, irwrite, pcwrite, pcsrc, memread, memwrite, regwrite;
  logic        reg2loc, alusrc, mem2reg, halted;
  logic [3:0]  aluop;
  logic [1:0]  signop;
  logic [2:0]  state;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instret;
`endif

  int compared = 0;
  int mismatched = 0;

  localparam logic [10:0] SReq = 11'h400, SIrw = 11'h200, SPcw = 11'h100, SPcs = 11'h080;
  localparam logic [10:0] SMrd = 11'h040, SMwr = 11'h020, SRgw = 11'h010, SR2l = 11'h008;
  localparam logic [10:0] SAsr = 11'h004, SM2r = 11'h002, SHlt = 11'h001;

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpAddi = 11'b10010001000;
  localparam logic [10:0] OpSubi = 11'b11010001000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpB    = 11'b00010100000;
  localparam logic [10:0] OpCbz  = 11'b10110100000;

  multicycle_control #(.WAIT_MAX(4)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .opcode   (opcode),
    .zero     (zero),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .irwrite  (irwrite),
    .pcwrite  (pcwrite),
    .pcsrc    (pcsrc),
    .memread  (memread),
    .memwrite (memwrite),
    .regwrite (regwrite),
    .reg2loc  (reg2loc),
    .alusrc   (alusrc),
    .mem2reg  (mem2reg),
    .aluop    (aluop),
    .signop   (signop),
    .state    (state),
`ifdef CTRL_PERF_CNT_EN
    .instret  (instret),
`endif
    .halted   (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] st, input logic [10:0] strb,
                     input logic [3:0] alu, input logic [1:0] sop);
    logic [19:0] obs, exp;
    #1;
    obs = {state, mem_req, irwrite, pcwrite, pcsrc, memread, memwrite, regwrite, reg2loc,
           alusrc, mem2reg, halted, aluop, signop};
    exp = {st, strb, alu, sop};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h (state,strobes,aluop,signop)", tag, obs, exp);
    end
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic chk32(input string tag, input logic [31:0] exp);
    compared++;
    assert (instret === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, instret, exp);
    end
  endtask
`endif

  // FETCH with zero-wait memory then DECODE; opcode is scrambled afterwards.
  task automatic fetch_decode(input string tag, input logic [10:0] op);
    opcode    = op;
    mem_ready = 1'b1;
    chk({tag, "_fetch"}, 3'd0, SReq | SIrw | SPcw, 4'b0000, 2'b00);
    tick();
    mem_ready = 1'b0;
    chk({tag, "_decode"}, 3'd1, 11'h000, 4'b0000, 2'b00);
    tick();
    opcode = 11'h000;
  endtask

  task automatic reg_op(input string tag, input logic [10:0] op, input logic [10:0] strb,
                        input logic [3:0] alu);
    fetch_decode(tag, op);
    chk({tag, "_exec"}, 3'd2, strb, alu, 2'b00);
    tick();
    mem_ready = 1'b1;
    chk({tag, "_wb"}, 3'd4, SRgw, 4'b0000, 2'b00);
    tick();
  endtask

  initial begin
    Reset = 1'b1; opcode = 11'h000; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset", 3'd0, 11'h000, 4'b0000, 2'b00);
`ifdef CTRL_PERF_CNT_EN
    chk32("instret_reset", 32'd0);
`endif
    Reset = 1'b0;

    // B
    fetch_decode("b", OpB);
    chk("b_exec", 3'd2, SPcw | SPcs, 4'b0000, 2'b10);
    tick();
`ifdef CTRL_PERF_CNT_EN
    chk32("instret_b", 32'd1);
`endif

    // STUR, zero-wait
    fetch_decode("stur", OpStur);
    chk("stur_exec", 3'd2, SAsr | SR2l, 4'b0010, 2'b01);
    tick();
`ifdef CTRL_PERF_CNT_EN
    chk32("instret_stur_exec", 32'd1);
`endif
    mem_ready = 1'b1;
    chk("stur_mem", 3'd3, SReq | SMwr | SAsr, 4'b0010, 2'b01);
    tick();
`ifdef CTRL_PERF_CNT_EN
    chk32("instret_stur", 32'd2);
`endif

    // ADD
    reg_op("add", OpAdd, 11'h000, 4'b0010);
`ifdef CTRL_PERF_CNT_EN
    chk32("instret_add", 32'd3);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    fetch_decode("bwrap", OpB);
    chk("bwrap_exec", 3'd2, SPcw | SPcs, 4'b0000, 2'b10);
    tick();
    chk32("instret_wrap", 32'd0);
`endif

    reg_op("and",  OpAnd,  11'h000,     4'b0000);
    reg_op("orr",  OpOrr,  11'h000,     4'b0001);
    reg_op("sub",  OpSub,  11'h000,     4'b0110);
    reg_op("addi", OpAddi, SAsr | SR2l, 4'b0010);
    reg_op("subi", OpSubi, SAsr | SR2l, 4'b0110);

    // LDUR with three wait cycles in MEM
    fetch_decode("ldur", OpLdur);
    chk("ldur_exec", 3'd2, SAsr, 4'b0010, 2'b01);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      chk("ldur_mem", 3'd3, SReq | SMrd | SAsr, 4'b0010, 2'b01);
      tick();
    end
    mem_ready = 1'b1;
    chk("ldur_wb", 3'd4, SRgw | SM2r, 4'b0000, 2'b00);
    tick();

    // CBZ taken / not taken
    fetch_decode("cbz1", OpCbz);
    zero = 1'b1;
    chk("cbz1_exec", 3'd2, SPcw | SPcs | SR2l, 4'b0111, 2'b11);
    tick();
    fetch_decode("cbz0", OpCbz);
    zero = 1'b0;
    chk("cbz0_exec", 3'd2, SPcs | SR2l, 4'b0111, 2'b11);
    tick();

    // Illegal opcode traps and stays silent
    fetch_decode("illegal", 11'b00000000000);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      chk("trap_hold", 3'd5, SHlt, 4'b0000, 2'b00);
      tick();
    end
    Reset = 1'b1;
    chk("trap_reset", 3'd0, 11'h000, 4'b0000, 2'b00);
    tick();
    Reset = 1'b0;

    // Fetch timeout: five waiting FETCH cycles then TRAP
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("timeout_fetch", 3'd0, SReq, 4'b0000, 2'b00);
      tick();
    end
    chk("timeout_trap", 3'd5, SHlt, 4'b0000, 2'b00);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;

    // Reset during a STUR memory wait
    fetch_decode("sturw", OpStur);
    chk("sturw_exec", 3'd2, SAsr | SR2l, 4'b0010, 2'b01);
    tick();
    chk("sturw_mem", 3'd3, SReq | SMwr | SAsr, 4'b0010, 2'b01);
    mem_ready = 1'b1;
    Reset     = 1'b1;
    chk("sturw_abort", 3'd0, 11'h000, 4'b0000, 2'b00);
    tick();
    Reset     = 1'b0;
    mem_ready = 1'b0;
    chk("post_reset_fetch", 3'd0, SReq, 4'b0000, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
